// File: rtl/debounce_pkg.sv
// Shared types and defaults for the pin-input debounce stages.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } deb_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin levels; both flops clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a bouncing pin and commits a new level only after it has held
// for DEBOUNCE_CYCLES consecutive synchronized samples.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic X_raw,
    output logic X_clean,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_x_sync;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_busy;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (X_raw),
        .q     (w_x_sync)
    );

    // Outputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                STABLE_LOW: begin
                    if (w_x_sync) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!w_x_sync) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_clean <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!w_x_sync) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (w_x_sync) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_clean <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign X_clean = r_clean;
    assign busy    = r_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a run-length reference model of the synchronized
// level is stepped every edge and compared against X_clean/busy.
module tb_input_debouncer;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    logic X_raw;
    logic X_clean;
    logic busy;

    int total = 0;
    int bad   = 0;

    // Reference model: raw samples delayed two edges, then a run counter of
    // consecutive samples disagreeing with the committed level.
    bit m_s1, m_sync, m_clean;
    int m_run;

    always #5 clk = ~clk;

    input_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .X_raw   (X_raw),
        .X_clean (X_clean),
        .busy    (busy)
    );

    task automatic model_clear();
        m_s1 = 0; m_sync = 0; m_clean = 0; m_run = 0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_clear();
        end else begin
            if (m_sync != m_clean) begin
                m_run++;
                if (m_run == D) begin
                    m_clean = ~m_clean;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_sync = m_s1;
            m_s1   = X_raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle_low();
        X_raw = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        X_raw = 1'b1;
        model_clear();
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (X_clean !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: X_clean=%b busy=%b required 0 0", X_clean, busy);
            end
        end
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if (X_clean !== (e >= 6)) begin
                bad++;
                $display("FAIL reset_release edge %0d: X_clean=%b required %b", e, X_clean, (e >= 6));
            end
        end
    endtask

    task automatic test_clean_edge();
        int rise_at, fall_at, busy_cnt;
        rise_at = -1; fall_at = -1; busy_cnt = 0;
        X_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (X_clean === 1'b1 && rise_at < 0) rise_at = e;
            total++;
            if (X_clean !== m_clean || busy !== (m_run > 0)) begin
                bad++;
                $display("FAIL clean_rise edge %0d: X_clean=%b busy=%b required %b %b", e, X_clean, busy, m_clean, (m_run > 0));
            end
        end
        total++;
        if (rise_at !== 6 || busy_cnt !== D - 1) begin
            bad++;
            $display("FAIL clean_rise_latency: rise=%0d busy_cycles=%0d required 6 %0d", rise_at, busy_cnt, D - 1);
        end
        X_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (X_clean === 1'b0 && fall_at < 0) fall_at = e;
        end
        total++;
        if (fall_at !== 6) begin
            bad++;
            $display("FAIL clean_fall_latency: fall=%0d required 6", fall_at);
        end
    endtask

    task automatic test_glitch();
        bit saw_busy, saw_high;
        saw_busy = 0; saw_high = 0;
        for (int e = 1; e <= 14; e++) begin
            X_raw = (e <= 3);
            tick();
            if (busy === 1'b1) saw_busy = 1;
            if (X_clean !== 1'b0) saw_high = 1;
            total++;
            if (X_clean !== m_clean || busy !== (m_run > 0)) begin
                bad++;
                $display("FAIL glitch edge %0d: X_clean=%b busy=%b required %b %b", e, X_clean, busy, m_clean, (m_run > 0));
            end
        end
        total++;
        if (saw_high || !saw_busy || busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_summary: saw_high=%b saw_busy=%b busy=%b required 0 1 0", saw_high, saw_busy, busy);
        end
    endtask

    task automatic test_bounce_train();
        logic [8:0] pat;
        int rise_at;
        pat = 9'b111101101;  // bit i applied before edge i+1: 1,0,1,1,0,1,1,1,1
        rise_at = -1;
        for (int e = 1; e <= 16; e++) begin
            X_raw = (e <= 9) ? pat[e-1] : 1'b1;
            tick();
            if (X_clean === 1'b1 && rise_at < 0) rise_at = e;
            total++;
            if (X_clean !== m_clean || busy !== (m_run > 0)) begin
                bad++;
                $display("FAIL bounce edge %0d: X_clean=%b busy=%b required %b %b", e, X_clean, busy, m_clean, (m_run > 0));
            end
        end
        total++;
        if (rise_at !== 11) begin
            bad++;
            $display("FAIL bounce_rise: edge=%0d required 11", rise_at);
        end
    endtask

    task automatic test_reset_mid_qual();
        X_raw = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        total++;
        if (busy !== 1'b1 || X_clean !== 1'b0) begin
            bad++;
            $display("FAIL midq_pre: busy=%b X_clean=%b required 1 0", busy, X_clean);
        end
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        total++;
        if (busy !== 1'b0 || X_clean !== 1'b0) begin
            bad++;
            $display("FAIL midq_async: busy=%b X_clean=%b required 0 0", busy, X_clean);
        end
        X_raw = 1'b0;
        tick();
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            total++;
            if (X_clean !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midq_after edge %0d: X_clean=%b busy=%b required 0 0", e, X_clean, busy);
            end
        end
    endtask

    task automatic test_random();
        int left;
        left = 0;
        for (int e = 0; e < 400; e++) begin
            if (left == 0) begin
                X_raw = ~X_raw;
                left  = $urandom_range(1, 7);
            end
            left--;
            tick();
            total++;
            if (X_clean !== m_clean || busy !== (m_run > 0)) begin
                bad++;
                $display("FAIL random edge %0d: X_clean=%b busy=%b required %b %b", e, X_clean, busy, m_clean, (m_run > 0));
            end
        end
    endtask

    task automatic test_chain_pulses();
        int presses, pulses;
        logic prev;
        presses = 0; pulses = 0;
        prev = X_clean;
        for (int w = 2; w <= 6; w++) begin
            if (w >= D) presses++;
            for (int c = 0; c < w + 12; c++) begin
                X_raw = (c < w);
                tick();
                if (X_clean === 1'b1 && prev === 1'b0) pulses++;
                prev = X_clean;
            end
        end
        total++;
        if (pulses !== presses) begin
            bad++;
            $display("FAIL chain_pulses: pulses=%0d required %0d", pulses, presses);
        end
    endtask

    initial begin
        X_raw = 1'b0;
        reset = 1'b0;
        model_clear();
        test_reset();
        settle_low();
        test_clean_edge();
        settle_low();
        test_glitch();
        settle_low();
        test_bounce_train();
        settle_low();
        test_reset_mid_qual();
        settle_low();
        test_random();
        settle_low();
        test_chain_pulses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
